// File: rtl/oled_cmd_receiver.sv
// oled_cmd_receiver: display-side model of the SSD1331 SPI link.
// Deserialises sclk/mosi/cs/dc (SPI mode 0, MSB first), frames command bytes
// into complete commands using the per-opcode length table, and tracks the
// display power and command-lock state.
// Ports:
//   clk, rst             system clock; asynchronous active-low reset
//   sclk, mosi, cs, dc   serial link (cs active-low, dc=0 marks a command byte)
//   res                  active-low display reset from the controller
//   frame_valid/ready    command-frame handshake; frame_bytes (byte 0 = opcode
//                        in the low bits, unused bytes 0), frame_len 1..11
//   pix_valid, pix_data  one-cycle strobe per data byte (dc=1)
//   disp_on, locked      display power and command-lock state
//   err_unknown          sticky: unknown opcode seen
//   err_overflow         sticky: frame completed while previous one still held
module oled_cmd_receiver #(
  parameter int unsigned MAX_LEN     = 11,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   mosi,
  input  logic                   cs,
  input  logic                   dc,
  input  logic                   res,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [MAX_LEN*8-1:0]   frame_bytes,
  output logic [3:0]             frame_len,
  output logic                   pix_valid,
  output logic [7:0]             pix_data,
  output logic                   disp_on,
  output logic                   locked,
  output logic                   err_unknown,
  output logic                   err_overflow
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned NSIG   = 5;
  localparam int unsigned SYNC_W = SYNC_STAGES * NSIG;
  // Idle levels of {res, cs, dc, mosi, sclk}: no reset, deselected.
  localparam logic [NSIG-1:0] SYNC_IDLE = 5'b11000;

  typedef enum logic [1:0] {HUNT, ARGS, EMIT} state_t;

  logic [SYNC_W-1:0] sync_q;
  logic              res_s, cs_s, dc_s, mosi_s, sclk_s, sclk_q, sclk_rise;
  logic [2:0]        bit_cnt;
  logic [6:0]        sh;
  logic              byte_vld, byte_dc, cmd_vld;
  logic [BYTE_W-1:0] byte_q;
  state_t            state, state_d;
  logic              start, store, emit;
  logic [LEN_W:0]    lut;
  logic [LEN_W-1:0]  cnt, len_q;
  logic [MAX_LEN-1:0][BYTE_W-1:0] fbuf;

  // Opcode length table: {unknown, length}.
  function automatic logic [LEN_W:0] lookup(input logic [BYTE_W-1:0] op);
    case (op)
      8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h2E, 8'h2F:
        lookup = {1'b0, 4'd1};
      8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0, 8'hA1, 8'hA2,
      8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE, 8'hFD, 8'h26:
        lookup = {1'b0, 4'd2};
      8'h15, 8'h75: lookup = {1'b0, 4'd3};
      8'h25:        lookup = {1'b0, 4'd5};
      8'h23:        lookup = {1'b0, 4'd7};
      8'h21:        lookup = {1'b0, 4'd8};
      8'h22:        lookup = {1'b0, 4'd11};
      default:      lookup = {1'b1, 4'd1};
    endcase
  endfunction

  // Link synchroniser: one shift chain carrying all five link signals.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= {SYNC_STAGES{SYNC_IDLE}};
    else      sync_q <= SYNC_W'({sync_q, res, cs, dc, mosi, sclk});
  end

  assign {res_s, cs_s, dc_s, mosi_s, sclk_s} = sync_q[SYNC_W-1 -: NSIG];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign cmd_vld   = byte_vld & ~byte_dc;
  assign lut       = lookup(byte_q);

  // Bit deserialiser; byte_vld pulses once per completed byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q   <= 1'b0;
      bit_cnt  <= '0;
      sh       <= '0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
      byte_dc  <= 1'b0;
    end else begin
      sclk_q   <= sclk_s;
      byte_vld <= 1'b0;
      if (!res_s || cs_s) begin
        bit_cnt <= '0;
        sh      <= '0;
      end else if (sclk_rise) begin
        sh      <= {sh[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_q   <= {sh, mosi_s};
          byte_dc  <= dc_s;
        end
      end
    end
  end

  // Parser state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HUNT;
    else      state <= state_d;
  end

  // Parser next state and datapath strobes.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    store   = 1'b0;
    emit    = 1'b0;
    case (state)
      HUNT: if (cmd_vld) begin
        start   = 1'b1;
        state_d = (lut[LEN_W-1:0] == 4'd1) ? EMIT : ARGS;
      end
      ARGS: if (cmd_vld) begin
        store = 1'b1;
        if (cnt + 4'd1 == len_q) state_d = EMIT;
      end
      EMIT: begin
        emit    = 1'b1;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
    if (!res_s) begin
      state_d = HUNT;
      start   = 1'b0;
      store   = 1'b0;
      emit    = 1'b0;
    end
  end

  // Frame assembly, handshake, side effects and pixel strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fbuf         <= '0;
      cnt          <= '0;
      len_q        <= '0;
      frame_valid  <= 1'b0;
      frame_bytes  <= '0;
      frame_len    <= '0;
      pix_valid    <= 1'b0;
      pix_data     <= '0;
      disp_on      <= 1'b0;
      locked       <= 1'b0;
      err_unknown  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      pix_valid <= byte_vld & byte_dc;
      if (byte_vld && byte_dc) pix_data <= byte_q;

      if (frame_valid && frame_ready) frame_valid <= 1'b0;

      if (start) begin
        fbuf    <= '0;
        fbuf[0] <= byte_q;
        cnt     <= 4'd1;
        len_q   <= lut[LEN_W-1:0];
        if (lut[LEN_W]) err_unknown <= 1'b1;
      end
      if (store) begin
        fbuf[cnt] <= byte_q;
        cnt       <= cnt + 4'd1;
      end

      // While locked only FD frames get through; others vanish silently.
      // A frame accepted this very cycle counts as already released.
      if (emit && (!locked || fbuf[0] == 8'hFD)) begin
        if (frame_valid && !frame_ready) begin
          err_overflow <= 1'b1;
        end else begin
          frame_valid <= 1'b1;
          frame_bytes <= fbuf;
          frame_len   <= len_q;
          if (fbuf[0] == 8'hAE) disp_on <= 1'b0;
          if (fbuf[0] == 8'hAF) disp_on <= 1'b1;
          if (fbuf[0] == 8'hFD && fbuf[1] == 8'h16) locked <= 1'b1;
          if (fbuf[0] == 8'hFD && fbuf[1] == 8'h12) locked <= 1'b0;
        end
      end

      if (!res_s) begin
        cnt     <= '0;
        disp_on <= 1'b0;
        locked  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_oled_cmd_receiver.sv
// Bench for oled_cmd_receiver: drives the SPI link byte by byte, keeps a
// byte-level reference model of the command framing, and compares captured
// frames, pixel bytes and status flags against it.
module tb_oled_cmd_receiver;

  localparam int HALF = 5;

  logic        clk, rst, sclk, mosi, cs, dc, res, frame_ready;
  logic        frame_valid, pix_valid, disp_on, locked, err_unknown, err_overflow;
  logic [87:0] frame_bytes;
  logic [3:0]  frame_len;
  logic [7:0]  pix_data;

  oled_cmd_receiver dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .dc(dc), .res(res),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_bytes(frame_bytes), .frame_len(frame_len),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .disp_on(disp_on), .locked(locked),
    .err_unknown(err_unknown), .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [3:0] len; logic [87:0] bytes; } frame_t;
  typedef struct { logic [7:0] op; int len; bit unk; } vec_t;

  int n_chk = 0, n_pass = 0;

  // Reference model state
  int         len_of[256];
  bit         unk_of[256];
  logic [7:0] pend[$];
  int         pend_len;
  bit         m_disp, m_lock, m_unk, m_ovf, m_ready, m_held;
  frame_t     exp_q[$], got_q[$];
  logic [7:0] exp_pix[$], got_pix[$];

  logic [7:0] ops1[8]  = '{8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h2E, 8'h2F};
  logic [7:0] ops2[19] = '{8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0,
                           8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB,
                           8'hBE, 8'hFD, 8'h26};
  logic [7:0] rect[11] = '{8'h22, 8'h00, 8'h00, 8'h5F, 8'h3F, 8'hFF, 8'h00, 8'h00,
                           8'h00, 8'hFF, 8'h00};
  vec_t tbl[25];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_frame();
    frame_t f;
    f.len   = 4'(pend.size());
    f.bytes = '0;
    foreach (pend[k]) f.bytes[8*k +: 8] = pend[k];
    if (m_lock && pend[0] != 8'hFD) return;
    if (!m_ready && m_held) begin
      m_ovf = 1'b1;
      return;
    end
    exp_q.push_back(f);
    if (!m_ready) m_held = 1'b1;
    if (pend[0] == 8'hAE) m_disp = 1'b0;
    if (pend[0] == 8'hAF) m_disp = 1'b1;
    if (pend[0] == 8'hFD && pend[1] == 8'h16) m_lock = 1'b1;
    if (pend[0] == 8'hFD && pend[1] == 8'h12) m_lock = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit d);
    if (d) begin
      exp_pix.push_back(b);
      return;
    end
    if (pend.size() == 0) begin
      pend_len = len_of[b];
      if (unk_of[b]) m_unk = 1'b1;
    end
    pend.push_back(b);
    if (pend.size() == pend_len) begin
      model_frame();
      pend.delete();
    end
  endfunction

  // Capture handshaken frames and pixel strobes on the falling edge.
  always @(negedge clk) begin
    if (rst && frame_valid && frame_ready) begin
      frame_t f;
      f.len   = frame_len;
      f.bytes = frame_bytes;
      got_q.push_back(f);
    end
    if (rst && pix_valid) got_pix.push_back(pix_data);
  end

  task automatic send_bits(input logic [7:0] b, input bit d, input int nbits, input bit keep_cs);
    @(negedge clk);
    cs = 1'b0;
    dc = d;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    if (nbits == 8) model_byte(b, d);
    repeat (2) @(negedge clk);
    if (!keep_cs) begin
      cs = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit d = 1'b0);
    send_bits(b, d, 8, 1'b0);
  endtask

  task automatic set_ready(input bit v);
    @(posedge clk);
    #1 frame_ready = v;
    m_ready = v;
    if (v) m_held = 1'b0;
  endtask

  task automatic flush(input string name);
    frame_t g, e;
    logic [7:0] gp, ep;
    repeat (30) @(negedge clk);
    chk({name, "_frames"}, 96'(got_q.size()), 96'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({name, "_frame"}, 96'({g.len, g.bytes}), 96'({e.len, e.bytes}));
    end
    got_q.delete();
    exp_q.delete();
    chk({name, "_pixels"}, 96'(got_pix.size()), 96'(exp_pix.size()));
    while (got_pix.size() > 0 && exp_pix.size() > 0) begin
      gp = got_pix.pop_front();
      ep = exp_pix.pop_front();
      chk({name, "_pix"}, 96'(gp), 96'(ep));
    end
    got_pix.delete();
    exp_pix.delete();
  endtask

  task automatic res_pulse();
    @(negedge clk);
    res = 1'b0;
    repeat (8) @(negedge clk);
    res = 1'b1;
    repeat (6) @(negedge clk);
    pend.delete();
    m_disp = 1'b0;
    m_lock = 1'b0;
  endtask

  task automatic chk_status(input string name);
    chk({name, "_disp"}, 96'(disp_on), 96'(m_disp));
    chk({name, "_lock"}, 96'(locked), 96'(m_lock));
    chk({name, "_unk"}, 96'(err_unknown), 96'(m_unk));
    chk({name, "_ovf"}, 96'(err_overflow), 96'(m_ovf));
  endtask

  initial begin
    bit exp_unk;
    int idx;
    logic [7:0] op;

    tbl = '{'{8'hAE, 1, 0}, '{8'hAF, 1, 0}, '{8'hA4, 1, 0}, '{8'hA7, 1, 0},
            '{8'h2E, 1, 0}, '{8'h2F, 1, 0}, '{8'h81, 2, 0}, '{8'h87, 2, 0},
            '{8'h8C, 2, 0}, '{8'hA0, 2, 0}, '{8'hAD, 2, 0}, '{8'hB3, 2, 0},
            '{8'hBE, 2, 0}, '{8'hFD, 2, 0}, '{8'h26, 2, 0}, '{8'h15, 3, 0},
            '{8'h75, 3, 0}, '{8'h25, 5, 0}, '{8'h23, 7, 0}, '{8'h21, 8, 0},
            '{8'h22, 11, 0}, '{8'h00, 1, 1}, '{8'h24, 1, 1}, '{8'hA3, 1, 1},
            '{8'hFF, 1, 1}};

    for (int i = 0; i < 256; i++) begin
      len_of[i] = 1;
      unk_of[i] = 1'b1;
    end
    foreach (ops1[k]) begin len_of[ops1[k]] = 1; unk_of[ops1[k]] = 1'b0; end
    foreach (ops2[k]) begin len_of[ops2[k]] = 2; unk_of[ops2[k]] = 1'b0; end
    len_of[8'h15] = 3;  unk_of[8'h15] = 1'b0;
    len_of[8'h75] = 3;  unk_of[8'h75] = 1'b0;
    len_of[8'h25] = 5;  unk_of[8'h25] = 1'b0;
    len_of[8'h23] = 7;  unk_of[8'h23] = 1'b0;
    len_of[8'h21] = 8;  unk_of[8'h21] = 1'b0;
    len_of[8'h22] = 11; unk_of[8'h22] = 1'b0;

    m_disp = 0; m_lock = 0; m_unk = 0; m_ovf = 0; m_ready = 1; m_held = 0;
    rst = 1'b0; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dc = 1'b0; res = 1'b1;
    frame_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", 96'({frame_valid, frame_len, pix_valid, pix_data, disp_on,
                           locked, err_unknown, err_overflow}), 96'(0));
    chk("reset_bytes", 96'(frame_bytes), 96'(0));
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Init sequence, cs toggled per byte
    send(8'hFD); send(8'h12); send(8'hAE); send(8'hA0); send(8'h72); send(8'hAF);
    flush("init");
    chk("init_disp", 96'(disp_on), 96'(1));
    chk("init_errs", 96'({err_unknown, err_overflow}), 96'(0));

    // Pixel bytes inside a 3-byte command
    send(8'h15); send(8'h00); send(8'h12, 1'b1); send(8'h34, 1'b1); send(8'h5F);
    flush("pix");

    // Partial AF aborted by cs, then a full AE
    send_bits(8'hAF, 1'b0, 5, 1'b0);
    send(8'hAE);
    flush("abort");
    chk("abort_disp", 96'(disp_on), 96'(0));

    // Length table
    exp_unk = 1'b0;
    for (int i = 0; i < 25; i++) begin
      send(tbl[i].op);
      for (int j = 1; j < tbl[i].len; j++)
        send((tbl[i].op == 8'hFD) ? 8'h12 : 8'($urandom_range(0, 255)));
      exp_unk |= tbl[i].unk;
      repeat (30) @(negedge clk);
      chk("tbl_len", 96'(got_q.size() > 0 ? got_q[$].len : 4'd0), 96'(tbl[i].len));
      chk("tbl_op", 96'(got_q.size() > 0 ? got_q[$].bytes[7:0] : 8'h5A), 96'(tbl[i].op));
      chk("tbl_unk", 96'(err_unknown), 96'(exp_unk));
      flush("tbl");
    end

    // Unknown opcode, then lock behaviour
    send(8'h99);
    flush("unk");
    chk("unk_flag", 96'(err_unknown), 96'(1));
    send(8'hAE);
    send(8'hFD); send(8'h16);
    flush("lock");
    chk("lock_set", 96'(locked), 96'(1));
    send(8'hAF);
    flush("locked_af");
    chk("locked_disp", 96'(disp_on), 96'(0));
    send(8'hFD); send(8'h12); send(8'hAF);
    flush("unlock");
    chk("unlock_disp", 96'({locked, disp_on}), 96'(2'b01));

    // Rectangle held with frame_ready low; following AE overflows
    set_ready(1'b0);
    foreach (rect[k]) send(rect[k]);
    send(8'hAE);
    repeat (30) @(negedge clk);
    chk("hold_valid", 96'(frame_valid), 96'(1));
    chk("hold_len", 96'(frame_len), 96'(11));
    chk("hold_bytes", 96'(frame_bytes), 96'(88'h00FF000000FF3F5F000022));
    chk("ovf_flag", 96'(err_overflow), 96'(1));
    chk("ovf_disp", 96'(disp_on), 96'(1));
    set_ready(1'b1);
    flush("rect");

    // Display reset mid-frame while locked
    send(8'hFD); send(8'h16);
    send(8'h21); send(8'h01); send(8'h02);
    res_pulse();
    send(8'hAE);
    flush("res");
    chk_status("res");

    // Randomised command stream
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 7) == 0)
        send_bits(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 7), 1'b0);
      idx = $urandom_range(0, 24);
      op  = tbl[idx].op;
      send_bits(op, 1'b0, 8, 1'($urandom_range(0, 1)));
      for (int j = 1; j < tbl[idx].len; j++) begin
        if ($urandom_range(0, 3) == 0)
          send_bits(8'($urandom_range(0, 255)), 1'b1, 8, 1'($urandom_range(0, 1)));
        if (op == 8'hFD)
          send_bits($urandom_range(0, 1) ? 8'h16 : 8'h12, 1'b0, 8, 1'b0);
        else
          send_bits(8'($urandom_range(0, 255)), 1'b0, 8, 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      cs = 1'b1;
      flush("rnd");
      chk_status("rnd");
    end
    send(8'hFD); send(8'h12); send(8'hAF);
    flush("rnd_end");

    // Asynchronous reset in the middle of an 8-byte command
    send(8'h21); send(8'h01); send(8'h02);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_outs", 96'({frame_valid, frame_len, pix_valid, pix_data, disp_on,
                          locked, err_unknown, err_overflow}), 96'(0));
    chk("arst_bytes", 96'(frame_bytes), 96'(0));
    pend.delete();
    m_disp = 0; m_lock = 0; m_unk = 0; m_ovf = 0; m_held = 0;
    got_q.delete(); exp_q.delete(); got_pix.delete(); exp_pix.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send(8'hAF);
    flush("post_rst");
    chk_status("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
